// File: rtl/sampq_pkg.sv
// Shared constants and helpers for the sample-queue arbiter.
package sampq_pkg;

  localparam int MAX_SRC = 8;

  localparam logic [1:0] SQA_ENABLE   = 2'd0;
  localparam logic [1:0] SQA_OVERFLOW = 2'd1;
  localparam logic [1:0] SQA_DROPCNT  = 2'd2;
  localparam logic [1:0] SQA_RRLAST   = 2'd3;

  // Number of set bits; used to add simultaneous drops to the counter.
  function automatic logic [3:0] popcount8(input logic [MAX_SRC-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sampq_arbiter_rr_pick.sv
// Round-robin picker: first requesting index searching upward from rr_last+1.
module rr_pick
  import sampq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [2:0]         rr_last_i,
  output logic               grant_valid_o,
  output logic [2:0]         grant_idx_o
);

  // Walk offsets 1..NUM_SRC from the last winner; the first hit wins.
  always_comb begin
    int idx;
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr_last_i) + k) % NUM_SRC;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!grant_valid_o && (j == idx) && req_i[j]) begin
          grant_valid_o = 1'b1;
          grant_idx_o   = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/sampq_arbiter.sv
// Merges per-source ADC samples into the single sample-queue write port.
// One holding register per source, round-robin service, sticky overflow
// flags and a saturating drop counter, configured over an 8-bit wishbone bus.
module sampq_arbiter
  import sampq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sq_active,
  input  logic [32*NUM_SRC-1:0]   src_sample,
  input  logic [NUM_SRC-1:0]      src_avail,
  output logic [31:0]             sq_sample,
  output logic [2:0]              sq_src,
  output logic                    sq_push,
  input  logic                    sq_ready,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_we_i,
  input  logic [15:0]             wb_adr_i,
  input  logic [7:0]              wb_dat_i,
  output logic [7:0]              wb_dat_o,
  output logic                    wb_ack_o
);

  logic [NUM_SRC-1:0]         en_q, en_d;
  logic [NUM_SRC-1:0]         ovf_q, ovf_d;
  logic [7:0]                 drop_q, drop_d;
  logic [NUM_SRC-1:0]         hold_valid_q, hold_valid_d;
  logic [NUM_SRC-1:0][31:0]   hold_data_q, hold_data_d;
  logic [2:0]                 rr_last_q, rr_last_d;
  logic                       push_q, push_d;
  logic [31:0]                out_data_q, out_data_d;
  logic [2:0]                 out_src_q, out_src_d;

  logic                       wr;
  logic [1:0]                 adr;
  logic                       g_valid;
  logic [2:0]                 g_idx;
  logic                       grant;
  logic [NUM_SRC-1:0]         gsel_vec, cap_vec, drop_vec, ovf_clr;
  logic [MAX_SRC-1:0]         drop_ext;
  logic [8:0]                 drop_sum;
  logic [31:0]                pick_data;
  logic                       unused_adr;

  assign wr         = wb_cyc_i & wb_stb_i & wb_we_i;
  assign adr        = wb_adr_i[1:0];
  assign unused_adr = ^wb_adr_i[15:2];
  assign wb_ack_o   = 1'b1;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
    .req_i         (hold_valid_q),
    .rr_last_i     (rr_last_q),
    .grant_valid_o (g_valid),
    .grant_idx_o   (g_idx)
  );

  // A grant needs a free output stage; a deactivated queue never grants.
  assign grant = g_valid && sq_active && (!push_q || sq_ready);

  // Next state for holding registers, output stage and config registers.
  always_comb begin
    en_d         = en_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    rr_last_d    = rr_last_q;
    push_d       = push_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    gsel_vec     = '0;
    cap_vec      = '0;
    drop_vec     = '0;
    ovf_clr      = '0;
    drop_ext     = '0;
    drop_sum     = '0;
    pick_data    = '0;

    for (int i = 0; i < NUM_SRC; i++) begin
      gsel_vec[i] = grant && (g_idx == 3'(i));
      cap_vec[i]  = src_avail[i] && en_q[i] && sq_active;
      if (g_idx == 3'(i)) pick_data = hold_data_q[i];
      // A slot being granted this cycle frees up in time for the new sample.
      if (cap_vec[i] && hold_valid_q[i] && !gsel_vec[i]) begin
        drop_vec[i] = 1'b1;
      end else if (cap_vec[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i]  = src_sample[32*i +: 32];
      end else if (gsel_vec[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end

    if (grant) begin
      push_d     = 1'b1;
      out_data_d = pick_data;
      out_src_d  = g_idx;
      rr_last_d  = g_idx;
    end else if (push_q && sq_ready) begin
      push_d = 1'b0;
    end

    if (!sq_active) begin
      hold_valid_d = '0;
      push_d       = 1'b0;
      rr_last_d    = 3'(NUM_SRC - 1);
    end

    if (wr && (adr == SQA_ENABLE) && !sq_active) en_d = wb_dat_i[NUM_SRC-1:0];
    if (wr && (adr == SQA_OVERFLOW)) ovf_clr = wb_dat_i[NUM_SRC-1:0];
    // New drops are OR'd in after the clear so a same-cycle set survives.
    ovf_d = (ovf_q & ~ovf_clr) | drop_vec;

    drop_ext[NUM_SRC-1:0] = drop_vec;
    drop_sum = {1'b0, drop_q} + {5'b00000, popcount8(drop_ext)};
    if (wr && (adr == SQA_DROPCNT)) drop_d = '0;
    else if (drop_sum > 9'd255)     drop_d = 8'hFF;
    else                            drop_d = drop_sum[7:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= '0;
      ovf_q        <= '0;
      drop_q       <= '0;
      hold_valid_q <= '0;
      hold_data_q  <= '0;
      rr_last_q    <= 3'(NUM_SRC - 1);
      push_q       <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
    end else begin
      en_q         <= en_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      rr_last_q    <= rr_last_d;
      push_q       <= push_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  // Combinational register read-back.
  always_comb begin
    wb_dat_o = '0;
    case (adr)
      SQA_ENABLE:   wb_dat_o[NUM_SRC-1:0] = en_q;
      SQA_OVERFLOW: wb_dat_o[NUM_SRC-1:0] = ovf_q;
      SQA_DROPCNT:  wb_dat_o = drop_q;
      default:      wb_dat_o = {5'b00000, rr_last_q};
    endcase
  end

  assign sq_push   = push_q;
  assign sq_sample = out_data_q;
  assign sq_src    = out_src_q;

endmodule

// File: tb/tb_sampq_arbiter.sv
// Directed bench for sampq_arbiter with NUM_SRC = 4.
module tb_sampq_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           sq_active;
  logic [32*N-1:0] src_sample;
  logic [N-1:0]   src_avail;
  logic [31:0]    sq_sample;
  logic [2:0]     sq_src;
  logic           sq_push;
  logic           sq_ready;
  logic           wb_stb_i, wb_cyc_i, wb_we_i;
  logic [15:0]    wb_adr_i;
  logic [7:0]     wb_dat_i;
  logic [7:0]     wb_dat_o;
  logic           wb_ack_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] rd;

  sampq_arbiter #(.NUM_SRC(N)) dut (
    .clk(clk), .rst(rst), .sq_active(sq_active),
    .src_sample(src_sample), .src_avail(src_avail),
    .sq_sample(sq_sample), .sq_src(sq_src), .sq_push(sq_push), .sq_ready(sq_ready),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = {14'b0, a}; wb_dat_i = d;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [7:0] d);
    wb_we_i = 1'b0;
    wb_adr_i = {14'b0, a};
    #1;
    d = wb_dat_o;
  endtask

  task automatic set_sample(input int i, input logic [31:0] v);
    src_sample[32*i +: 32] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL reset_push: got %h want 0", sq_push); end
    total++; if (sq_sample !== 32'h0) begin bad++; $display("FAIL reset_sample: got %h want 0", sq_sample); end
    total++; if (sq_src !== 3'd0) begin bad++; $display("FAIL reset_src: got %h want 0", sq_src); end
    total++; if (wb_ack_o !== 1'b1) begin bad++; $display("FAIL reset_ack: got %h want 1", wb_ack_o); end
    wb_read(2'd0, rd);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL reset_enable: got %h want 00", rd); end
    wb_read(2'd1, rd);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL reset_overflow: got %h want 00", rd); end
    wb_read(2'd2, rd);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL reset_dropcnt: got %h want 00", rd); end
    wb_read(2'd3, rd);
    total++; if (rd !== 8'h03) begin bad++; $display("FAIL reset_rrlast: got %h want 03", rd); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    sq_active = 1'b0;
    wb_write(2'd0, 8'h01);
    sq_active = 1'b1; sq_ready = 1'b1;
    set_sample(0, 32'hDEADBEEF);
    src_avail = 4'b0001;
    tick();
    src_avail = '0;
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL single_t1_push: got %h want 0", sq_push); end
    tick();
    total++; if (sq_push !== 1'b1) begin bad++; $display("FAIL single_t2_push: got %h want 1", sq_push); end
    total++; if (sq_sample !== 32'hDEADBEEF) begin bad++; $display("FAIL single_sample: got %h want deadbeef", sq_sample); end
    total++; if (sq_src !== 3'd0) begin bad++; $display("FAIL single_src: got %h want 0", sq_src); end
    tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL single_t3_push: got %h want 0", sq_push); end
  endtask

  task automatic test_multi();
    sq_active = 1'b0;
    wb_write(2'd0, 8'h0F);
    sq_active = 1'b1; sq_ready = 1'b1;
    for (int i = 0; i < N; i++) set_sample(i, 32'h10 + 32'(i));
    src_avail = 4'b1111;
    tick();
    src_avail = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      total++; if (sq_push !== 1'b1) begin bad++; $display("FAIL multi_push%0d: got %h want 1", k, sq_push); end
      total++; if (sq_src !== 3'(k)) begin bad++; $display("FAIL multi_src%0d: got %h want %0d", k, sq_src, k); end
      total++; if (sq_sample !== 32'h10 + 32'(k)) begin bad++; $display("FAIL multi_sample%0d: got %h want %h", k, sq_sample, 32'h10 + 32'(k)); end
    end
    wb_read(2'd3, rd);
    total++; if (rd !== 8'h03) begin bad++; $display("FAIL multi_rrlast: got %h want 03", rd); end
    tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL multi_idle: got %h want 0", sq_push); end
  endtask

  task automatic test_backpressure();
    sq_ready = 1'b0;
    src_avail = 4'b0100;
    set_sample(2, 32'hAAAA0001); tick();
    set_sample(2, 32'hBBBB0002); tick();
    set_sample(2, 32'hCCCC0003); tick();
    src_avail = '0;
    total++; if (sq_push !== 1'b1) begin bad++; $display("FAIL bp_push: got %h want 1", sq_push); end
    total++; if (sq_src !== 3'd2) begin bad++; $display("FAIL bp_src: got %h want 2", sq_src); end
    total++; if (sq_sample !== 32'hAAAA0001) begin bad++; $display("FAIL bp_sampleA: got %h want aaaa0001", sq_sample); end
    tick();
    total++; if (sq_sample !== 32'hAAAA0001) begin bad++; $display("FAIL bp_stable: got %h want aaaa0001", sq_sample); end
    wb_read(2'd1, rd);
    total++; if (rd !== 8'h04) begin bad++; $display("FAIL bp_overflow: got %h want 04", rd); end
    wb_read(2'd2, rd);
    total++; if (rd !== 8'h01) begin bad++; $display("FAIL bp_dropcnt: got %h want 01", rd); end
    sq_ready = 1'b1;
    tick();
    total++; if (sq_push !== 1'b1) begin bad++; $display("FAIL bp_pushB: got %h want 1", sq_push); end
    total++; if (sq_sample !== 32'hBBBB0002) begin bad++; $display("FAIL bp_sampleB: got %h want bbbb0002", sq_sample); end
    tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL bp_drain: got %h want 0", sq_push); end
  endtask

  task automatic test_disabled();
    sq_active = 1'b0;
    wb_write(2'd0, 8'h02);
    sq_active = 1'b1;
    set_sample(0, 32'h00000055);
    src_avail = 4'b0001;
    tick();
    src_avail = '0;
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL dis_push1: got %h want 0", sq_push); end
    tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL dis_push2: got %h want 0", sq_push); end
    wb_read(2'd1, rd);
    total++; if (rd !== 8'h04) begin bad++; $display("FAIL dis_overflow: got %h want 04", rd); end
    wb_read(2'd2, rd);
    total++; if (rd !== 8'h01) begin bad++; $display("FAIL dis_dropcnt: got %h want 01", rd); end
    wb_write(2'd0, 8'h0F);
    wb_read(2'd0, rd);
    total++; if (rd !== 8'h02) begin bad++; $display("FAIL dis_enable_locked: got %h want 02", rd); end
  endtask

  task automatic test_saturate();
    sq_active = 1'b0;
    wb_write(2'd0, 8'h01);
    sq_active = 1'b1; sq_ready = 1'b0;
    set_sample(0, 32'h00000077);
    src_avail = 4'b0001;
    for (int c = 0; c < 300; c++) tick();
    wb_read(2'd2, rd);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL sat_dropcnt: got %h want ff", rd); end
    wb_write(2'd2, 8'h00);
    src_avail = '0;
    wb_read(2'd2, rd);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL sat_clear_wins: got %h want 00", rd); end
    wb_read(2'd1, rd);
    total++; if (rd !== 8'h05) begin bad++; $display("FAIL sat_overflow: got %h want 05", rd); end
    src_avail = 4'b0001;
    wb_write(2'd1, 8'h01);
    src_avail = '0;
    wb_read(2'd1, rd);
    total++; if (rd !== 8'h05) begin bad++; $display("FAIL ovf_set_wins: got %h want 05", rd); end
    wb_read(2'd2, rd);
    total++; if (rd !== 8'h01) begin bad++; $display("FAIL sat_recount: got %h want 01", rd); end
    wb_write(2'd1, 8'h04);
    wb_read(2'd1, rd);
    total++; if (rd !== 8'h01) begin bad++; $display("FAIL ovf_clear2: got %h want 01", rd); end
    wb_write(2'd1, 8'h01);
    wb_read(2'd1, rd);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL ovf_clear0: got %h want 00", rd); end
    wb_write(2'd3, 8'h00);
    wb_write(2'd2, 8'h00);
    wb_read(2'd2, rd);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL sat_clear2: got %h want 00", rd); end
  endtask

  task automatic test_flush();
    sq_active = 1'b0;
    wb_write(2'd0, 8'h0F);
    sq_active = 1'b1; sq_ready = 1'b0;
    for (int i = 0; i < N; i++) set_sample(i, 32'h20 + 32'(i));
    src_avail = 4'b1111;
    tick();
    src_avail = '0;
    tick();
    total++; if (sq_push !== 1'b1) begin bad++; $display("FAIL flush_pre_push: got %h want 1", sq_push); end
    total++; if (sq_sample !== 32'h20) begin bad++; $display("FAIL flush_pre_sample: got %h want 20", sq_sample); end
    sq_active = 1'b0;
    tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL flush_push: got %h want 0", sq_push); end
    sq_active = 1'b1; sq_ready = 1'b1;
    tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL flush_stale1: got %h want 0", sq_push); end
    tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL flush_stale2: got %h want 0", sq_push); end
    set_sample(3, 32'h33);
    src_avail = 4'b1000;
    tick();
    src_avail = '0;
    tick();
    total++; if (sq_push !== 1'b1) begin bad++; $display("FAIL flush_new_push: got %h want 1", sq_push); end
    total++; if (sq_src !== 3'd3) begin bad++; $display("FAIL flush_new_src: got %h want 3", sq_src); end
    total++; if (sq_sample !== 32'h33) begin bad++; $display("FAIL flush_new_sample: got %h want 33", sq_sample); end
    tick();
  endtask

  task automatic test_reset_mid();
    sq_ready = 1'b0;
    set_sample(1, 32'h44);
    src_avail = 4'b0010;
    tick(); tick(); tick();
    wb_read(2'd1, rd);
    total++; if (rd !== 8'h02) begin bad++; $display("FAIL mid_pre_overflow: got %h want 02", rd); end
    rst = 1'b1;
    src_avail = 4'b1111;
    tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL mid_push: got %h want 0", sq_push); end
    total++; if (sq_sample !== 32'h0) begin bad++; $display("FAIL mid_sample: got %h want 0", sq_sample); end
    total++; if (sq_src !== 3'd0) begin bad++; $display("FAIL mid_src: got %h want 0", sq_src); end
    wb_read(2'd0, rd);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL mid_enable: got %h want 00", rd); end
    wb_read(2'd1, rd);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL mid_overflow: got %h want 00", rd); end
    wb_read(2'd2, rd);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL mid_dropcnt: got %h want 00", rd); end
    wb_read(2'd3, rd);
    total++; if (rd !== 8'h03) begin bad++; $display("FAIL mid_rrlast: got %h want 03", rd); end
    rst = 1'b0;
    src_avail = '0;
    sq_ready = 1'b1;
    tick(); tick();
    total++; if (sq_push !== 1'b0) begin bad++; $display("FAIL mid_post_push: got %h want 0", sq_push); end
  endtask

  initial begin
    rst = 1'b1; sq_active = 1'b0; sq_ready = 1'b0;
    src_sample = '0; src_avail = '0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_disabled();
    test_saturate();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sampq_arbiter.md
# sampq_arbiter

Round-robin arbiter that merges the 32-bit sample outputs of several sampadcacc instances into the single sample-queue write port. Each source gets a one-entry holding register. Sources are served fairly under queue back-pressure. Lost samples are recorded per source in sticky overflow flags and in a saturating drop counter. Sits between the ADC accumulator array and the sample-queue FIFO; configured over the same 8-bit wishbone bus.

## Interface
- NUM_SRC, 4, number of sample sources (2..8).
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- sq_active  in  1  sample queue running; low flushes all sample state.
- src_sample  in  32*NUM_SRC  source i sample at bits [32*i+31:32*i].
- src_avail  in  NUM_SRC  one-cycle strobe: source i sample valid this cycle.
- sq_sample  out  32  sample presented to the queue.
- sq_src  out  3  index of the source of sq_sample.
- sq_push  out  1  sq_sample/sq_src valid.
- sq_ready  in  1  queue accepts; a transfer occurs when sq_push && sq_ready.
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  wishbone strobe/cycle/write.
- wb_adr_i  in  16  address; only [1:0] decoded.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data (combinational).
- wb_ack_o  out  1  tied to 1.

## Operation
- Registers. A write is `wb_cyc_i && wb_stb_i && wb_we_i`.
  - adr 0 is src_enable[NUM_SRC-1:0]. Writable only while !sq_active. Upper bits read 0.
  - adr 1 is overflow[NUM_SRC-1:0]. Sticky. Writing 1 clears that bit; writable any time.
  - adr 2 is drop_cnt[7:0]. Saturates at 255. Any write clears it.
  - adr 3 reads {5'b0, rr_last}. Writes to adr 3 are ignored.
- Capture. On src_avail[i] && src_enable[i] && sq_active, hold_data[i] <= sample and hold_valid[i] <= 1. A strobe from a disabled source is ignored and is not counted as a drop.
- Arbitration.
  - Eligible sources are those with hold_valid set.
  - The grant goes to the first eligible index searching upward (modulo NUM_SRC) from rr_last+1.
  - A grant happens only when the output stage is free, i.e. !sq_push || sq_ready.
  - On grant: the output register loads hold_data/index, sq_push <= 1, hold_valid[g] <= 0, rr_last <= g.
- Output stage. sq_push falls when sq_push && sq_ready and no new grant occurs in that cycle.
- Simultaneous capture and grant on the same source: the old entry moves to the output and the new sample loads the hold register. No drop.
- Drop. If src_avail[i] arrives while hold_valid[i] is set and source i is not granted this cycle:
  - the new sample is discarded and hold_data is kept;
  - overflow[i] <= 1;
  - drop_cnt increments, saturating.
  - If several sources drop in the same cycle, drop_cnt increments by the popcount, saturating at 255.
- Drop-count clear racing an increment: the clear wins.
- Overflow-bit clear racing a set on the same bit: the set wins.
- Flush. While !sq_active:
  - hold_valid all 0, sq_push 0, rr_last = NUM_SRC-1;
  - a push pending when sq_active falls is discarded;
  - overflow and drop_cnt are retained.

## Timing
- Reset values:
  - sq_push 0, sq_sample 0, sq_src 0;
  - hold_valid 0, src_enable 0, overflow 0, drop_cnt 0;
  - rr_last NUM_SRC-1, so source 0 is first priority.
- Latency from src_avail at cycle t:
  - hold_valid at t+1;
  - sq_push at t+2 if the output stage is free and the source wins arbitration.
- Throughput: one sample per cycle with sq_ready held high.
- sq_sample and sq_src stay stable while sq_push && !sq_ready.
- Register writes take effect the next cycle. Reads reflect current register state.
- rst has priority over every other input.

## Structure
- Shared package `sampq_pkg` holds:
  - register address constants SQA_ENABLE=0, SQA_OVERFLOW=1, SQA_DROPCNT=2, SQA_RRLAST=3;
  - MAX_SRC=8.
- One sub-module, `rr_pick`: purely combinational.
  - Inputs: request vector and rr_last.
  - Outputs: grant_valid and grant index.
- Holding registers, output stage, counters and wishbone decode live in the top module.

## Test plan
- Enable 0x1; pulse src_avail[0] with 0xDEADBEEF at t, sq_ready=1 -> sq_push high at t+2 for 1 cycle, sq_sample=0xDEADBEEF, sq_src=0.
- Enable 0xF; pulse avail on sources 0–3 in the same cycle (values 0x10..0x13) -> four consecutive pushes in order 0,1,2,3; adr 3 reads 3.
- sq_ready=0; source 2 strobes 3 times (A, B, C) -> push holds A, hold keeps B, C dropped; overflow reads 0x04, drop_cnt=1; release sq_ready -> A then B delivered.
- Enable 0x2; strobe source 0 -> no push, overflow and drop_cnt unchanged; write adr 0 while sq_active=1 -> enable unchanged.
- Back-pressure a source for 300 overflowing strobes -> drop_cnt=255. Write adr 2 -> reads 0. Write 0x04 to adr 1 -> bit 2 cleared.
- Fill holds and a pending push, then drop sq_active for 1 cycle -> sq_push 0 next cycle, no stale sample after re-activation; rst mid-stream -> all reset values.
